cpu_out_capture: RTL and testbench
==================================

Name: cpu_out_capture

Overview:
- Parametrised capture buffer for the CPU result port (outFlag/out).
- Every cycle where outFlag is high, it records out together with a cycle timestamp in a FIFO of DEPTH entries.
- A valid/ready port drains the FIFO to a host, bench or debug bridge.
- Three capture modes are supported: stop-on-full, overwrite-oldest and one-shot freeze. This replaces the hand-clocked, unobserved result checking with a reusable on-chip trace.

Parameters:
- WIDTH, 32, data width of out / rd_data
- DEPTH, 16, FIFO entries; power of two, >= 2
- STAMPWIDTH, 16, timestamp counter width
- DROPWIDTH, 8, width of the saturating dropped-sample counter

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of FIFO, counters and state
- enable  in  1  capture enable
- mode  in  2  0=STOP, 1=OVERWRITE, 2=ONESHOT, 3=reserved (behaves as STOP)
- outFlag  in  1  CPU result-valid strobe
- out  in  WIDTH  CPU result value
- rd_ready  in  1  consumer ready
- rd_valid  out  1  head entry available
- rd_data  out  WIDTH  head entry data
- rd_stamp  out  STAMPWIDTH  head entry timestamp
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- frozen  out  1  ONESHOT capture has stopped
- dropped  out  DROPWIDTH  samples lost, saturating

Behaviour:
Reset and clear
- While reset is low: head=tail=0, count=0, stamp=0, dropped=0, state=CAPTURE.
- Resulting outputs: rd_valid=0, rd_data=0, rd_stamp=0, empty=1, full=0, frozen=0.
- Reset asserted mid-transfer discards all contents immediately; it does not wait for a clock edge.
- clear=1 on an edge has the same effect as reset, synchronously. It has priority over write and read in that cycle.

Timestamp
- stamp increments by 1 every cycle after reset and wraps modulo 2^STAMPWIDTH.
- A written entry stores the stamp value of its capture cycle, i.e. the pre-increment value.

Write and read
- Write request: wr = enable & outFlag & (state==CAPTURE).
- Read handshake: rd = rd_valid & rd_ready.
- The read port is first-word-fall-through. rd_valid = !empty. rd_data/rd_stamp show the head entry combinationally from storage, and show 0 when empty.
- Zero-latency path: a write at edge N makes rd_valid high after edge N if the FIFO was empty.
- The head changes only on rd, or on an overwrite drop. rd_data is held stable while rd_valid & !rd_ready, except in OVERWRITE mode.

Boundary cases
- Not full: wr writes at tail; tail, head and count wrap modulo DEPTH.
- Full with rd in the same cycle: the write is accepted in all modes and count stays DEPTH.
- Full, wr, no rd, mode STOP/reserved: the sample is discarded and dropped increments, saturating at all-ones.
- Full, wr, no rd, mode OVERWRITE: the oldest entry is discarded and head advances. The new entry is written, count stays DEPTH and dropped increments.
- Full, wr, no rd, mode ONESHOT: handled as STOP.
- Empty with rd: impossible, since rd_valid=0.
- Simultaneous wr and rd when not full or empty: count is unchanged.

State machine (2 states)
- CAPTURE -> FROZEN when mode==ONESHOT and count reaches DEPTH, evaluated on the post-update count.
- FROZEN: no writes; outFlag samples are ignored and not counted as dropped. Reads continue normally. frozen=1.
- FROZEN -> CAPTURE only on clear or reset. Draining the FIFO does not re-arm capture.
- Changing mode mid-operation takes effect on the next edge and does not alter stored data. Leaving ONESHOT while FROZEN keeps the block frozen until clear.

Decomposition:
- Package cpu_capture_pkg holds:
  - capture_mode_e enum (CAP_STOP=0, CAP_OVERWRITE=1, CAP_ONESHOT=2)
  - cap_state_e enum (CAPTURE, FROZEN)
  - packed entry struct {data, stamp}
- One sub-module, capture_fifo_mem: a DEPTH x (WIDTH+STAMPWIDTH) register array with one write port and an asynchronous read port. It has no reset on storage.
- Pointer, count, mode and FSM logic stay in the top module.

Test Plan:
1. Reset, then enable=1, mode=0; pulse outFlag with out=5, 7, 9 on cycles 3, 4, 6; rd_ready=1 from cycle 10 -> three entries read in order 5/3, 7/4, 9/6 (data/stamp), then empty=1 and dropped=0.
2. DEPTH=16, mode=0, rd_ready=0, 20 consecutive outFlag with out=1..20 -> full=1, count=16, dropped=4; drain yields 1..16.
3. Same stimulus as 2 with mode=1 -> dropped=4; drain yields 5..20 with consecutive stamps.
4. mode=2, 16 writes, then 5 more outFlag -> frozen=1 after the 16th write and dropped=0; drain yields 1..16; further outFlag is ignored until clear=1, after which one write of 0xAA is read back.
5. FIFO full, outFlag and rd_ready both high for 3 cycles, mode=0 -> count stays 16, dropped=0, writes accepted.
6. Reset low mid-drain with count=8 -> outputs clear immediately without a clock edge: rd_valid=0, empty=1, stamp restarts at 0; 300 forced drops with DROPWIDTH=8 show dropped saturates at 255.

Source files
------------

// File: rtl/cpu_capture_pkg.sv
// Shared types for the CPU result capture buffer: capture modes, FSM states
// and the default-width view of one trace entry.
package cpu_capture_pkg;

    typedef enum logic [1:0] {
        CAP_STOP      = 2'd0,
        CAP_OVERWRITE = 2'd1,
        CAP_ONESHOT   = 2'd2
    } capture_mode_e;

    typedef enum logic {
        CAPTURE = 1'b0,
        FROZEN  = 1'b1
    } cap_state_e;

    localparam int ENTRY_DATA_W  = 32;
    localparam int ENTRY_STAMP_W = 16;

    // Layout of a stored sample at the default WIDTH/STAMPWIDTH
    typedef struct packed {
        logic [ENTRY_DATA_W-1:0]  data;
        logic [ENTRY_STAMP_W-1:0] stamp;
    } cap_entry_t;

endpackage

// File: rtl/cpu_out_capture_if.sv
// Result strobe in, trace drain out: the bus between the CPU/host side
// (master) and the capture buffer (slave).
interface cpu_out_capture_if #(
    parameter int WIDTH      = 32,
    parameter int STAMPWIDTH = 16
);
    logic                  outFlag;
    logic [WIDTH-1:0]      out;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [WIDTH-1:0]      rd_data;
    logic [STAMPWIDTH-1:0] rd_stamp;

    modport master (
        output outFlag, out, rd_ready,
        input  rd_valid, rd_data, rd_stamp
    );

    modport slave (
        input  outFlag, out, rd_ready,
        output rd_valid, rd_data, rd_stamp
    );
endinterface

// File: rtl/capture_fifo_mem.sv
// Trace storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately unreset; validity is tracked by the pointers.
module capture_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int ENTRYWIDTH = 48
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRYWIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRYWIDTH-1:0]    rdata
);
    logic [ENTRYWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_out_capture.sv
// Capture buffer for the CPU result port: records out/timestamp pairs on outFlag
// into a FIFO and drains them through a first-word-fall-through valid/ready port.
module cpu_out_capture
    import cpu_capture_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int STAMPWIDTH = 16,
    parameter int DROPWIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [1:0]             mode,
    cpu_out_capture_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   frozen,
    output logic [DROPWIDTH-1:0]   dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]      data;
        logic [STAMPWIDTH-1:0] stamp;
    } slot_t;

    cap_state_e            state, state_next;
    logic [AW-1:0]         head, head_next;
    logic [AW-1:0]         tail, tail_next;
    logic [CW-1:0]         count_next;
    logic [STAMPWIDTH-1:0] stamp, stamp_next;
    logic [DROPWIDTH-1:0]  dropped_next;
    logic                  wr, rd, mem_we, head_adv, drop;
    logic                  overwrite_mode, oneshot_mode;
    slot_t                 wr_slot, head_slot;

    assign overwrite_mode = (mode == CAP_OVERWRITE);
    assign oneshot_mode   = (mode == CAP_ONESHOT);

    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    assign frozen = (state == FROZEN);

    assign wr = enable & bus.outFlag & (state == CAPTURE);
    assign rd = bus.rd_valid & bus.rd_ready;

    // Storage is never reset, so the head is masked to zero whenever empty
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = empty ? '0 : head_slot.data;
    assign bus.rd_stamp = empty ? '0 : head_slot.stamp;

    assign wr_slot = '{data: bus.out, stamp: stamp};

    capture_fifo_mem #(
        .DEPTH     (DEPTH),
        .ENTRYWIDTH($bits(slot_t))
    ) u_mem (
        .clock(clock),
        .we   (mem_we),
        .waddr(tail),
        .wdata(wr_slot),
        .raddr(head),
        .rdata(head_slot)
    );

    always_comb begin
        state_next   = state;
        head_next    = head;
        tail_next    = tail;
        count_next   = count;
        stamp_next   = stamp + STAMPWIDTH'(1);
        dropped_next = dropped;
        mem_we       = 1'b0;
        head_adv     = 1'b0;
        drop         = 1'b0;
        if (clear) begin
            state_next   = CAPTURE;
            head_next    = '0;
            tail_next    = '0;
            count_next   = '0;
            stamp_next   = '0;
            dropped_next = '0;
        end else begin
            // A full FIFO still accepts a write when a read or an overwrite frees a slot
            mem_we   = wr & (!full | rd | overwrite_mode);
            head_adv = rd | (wr & full & overwrite_mode);
            drop     = wr & full & !rd;
            if (mem_we) begin
                tail_next = tail + AW'(1);
            end
            if (head_adv) begin
                head_next = head + AW'(1);
            end
            count_next = count + CW'(mem_we) - CW'(head_adv);
            if (drop && (dropped != '1)) begin
                dropped_next = dropped + DROPWIDTH'(1);
            end
            if ((state == CAPTURE) && oneshot_mode && (count_next == FULL_COUNT)) begin
                state_next = FROZEN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= CAPTURE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            stamp   <= '0;
            dropped <= '0;
        end else begin
            state   <= state_next;
            head    <= head_next;
            tail    <= tail_next;
            count   <= count_next;
            stamp   <= stamp_next;
            dropped <= dropped_next;
        end
    end

endmodule

// File: tb/tb_cpu_out_capture.sv
// Bench for cpu_out_capture: hand-derived vectors and corner sequences plus
// randomized traffic compared every cycle against a queue-based reference.
module tb_cpu_out_capture;
    import cpu_capture_pkg::*;

    localparam int DEPTH    = 16;
    localparam int DROP_MAX = 255;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic       enable;
    logic [1:0] mode;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       frozen;
    logic [7:0] dropped;

    int errors;
    int checks;

    cap_entry_t model_q[$];
    int         m_stamp;
    int         m_drop;
    bit         m_frozen;

    typedef struct packed {
        logic        flag;
        logic [31:0] val;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [15:0] exp_stamp;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t vecs[13];

    cpu_out_capture_if #(.WIDTH(32), .STAMPWIDTH(16)) bus();

    cpu_out_capture #(
        .WIDTH     (32),
        .DEPTH     (DEPTH),
        .STAMPWIDTH(16),
        .DROPWIDTH (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .mode   (mode),
        .bus    (bus),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .frozen (frozen),
        .dropped(dropped)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        m_stamp  = 0;
        m_drop   = 0;
        m_frozen = 1'b0;
    endtask

    // Reference rules: a read pops the oldest sample, a write appends; a full
    // queue either loses the newcomer or (overwrite) its oldest sample.
    task automatic model_step();
        cap_entry_t e;
        bit         do_wr;
        bit         do_rd;
        if (clear) begin
            model_reset();
            return;
        end
        do_rd   = bus.rd_ready && (model_q.size() > 0);
        do_wr   = enable && bus.outFlag && !m_frozen;
        e.data  = bus.out;
        e.stamp = 16'(m_stamp);
        if (do_rd) void'(model_q.pop_front());
        if (do_wr) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(e);
            end else begin
                if (mode == 2'd1) begin
                    void'(model_q.pop_front());
                    model_q.push_back(e);
                end
                if (m_drop < DROP_MAX) m_drop++;
            end
        end
        if (mode == 2'd2 && model_q.size() == DEPTH) m_frozen = 1'b1;
        m_stamp = (m_stamp + 1) % 65536;
    endtask

    task automatic compare_model();
        logic [31:0] hd;
        logic [15:0] hs;
        hd = '0;
        hs = '0;
        if (model_q.size() > 0) begin
            hd = model_q[0].data;
            hs = model_q[0].stamp;
        end
        checkOutput("m_rd_valid", 64'(bus.rd_valid), 64'(model_q.size() > 0));
        checkOutput("m_rd_data",  64'(bus.rd_data),  64'(hd));
        checkOutput("m_rd_stamp", 64'(bus.rd_stamp), 64'(hs));
        checkOutput("m_count",    64'(count),        64'(model_q.size()));
        checkOutput("m_full",     64'(full),         64'(model_q.size() == DEPTH));
        checkOutput("m_empty",    64'(empty),        64'(model_q.size() == 0));
        checkOutput("m_frozen",   64'(frozen),       64'(m_frozen));
        checkOutput("m_dropped",  64'(dropped),      64'(m_drop));
    endtask

    task automatic applyStimulus(input logic flag, input logic [31:0] val, input logic rdy);
        bus.outFlag  = flag;
        bus.out      = val;
        bus.rd_ready = rdy;
        model_step();
        @(posedge clock);
        #1;
        compare_model();
    endtask

    // Called away from any edge; outputs must clear before the next clock
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("rst_empty",    64'(empty),        64'd1);
        checkOutput("rst_full",     64'(full),         64'd0);
        checkOutput("rst_count",    64'(count),        64'd0);
        checkOutput("rst_rd_data",  64'(bus.rd_data),  64'd0);
        checkOutput("rst_rd_stamp", 64'(bus.rd_stamp), 64'd0);
        checkOutput("rst_frozen",   64'(frozen),       64'd0);
        checkOutput("rst_dropped",  64'(dropped),      64'd0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        clear        = 1'b0;
        enable       = 1'b0;
        mode         = 2'd0;
        bus.outFlag  = 1'b0;
        bus.out      = '0;
        bus.rd_ready = 1'b0;
        #1;
        do_reset();

        // Three sparse captures, then a drain; stamps follow the edge index
        vecs[0]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 16'd0, 5'd0};
        vecs[1]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 16'd0, 5'd0};
        vecs[2]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 16'd0, 5'd0};
        vecs[3]  = '{1'b1, 32'd5, 1'b0, 1'b1, 32'd5, 16'd3, 5'd1};
        vecs[4]  = '{1'b1, 32'd7, 1'b0, 1'b1, 32'd5, 16'd3, 5'd2};
        vecs[5]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 16'd3, 5'd2};
        vecs[6]  = '{1'b1, 32'd9, 1'b0, 1'b1, 32'd5, 16'd3, 5'd3};
        vecs[7]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 16'd3, 5'd3};
        vecs[8]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 16'd3, 5'd3};
        vecs[9]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 16'd3, 5'd3};
        vecs[10] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd7, 16'd4, 5'd2};
        vecs[11] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd9, 16'd6, 5'd1};
        vecs[12] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 16'd0, 5'd0};
        enable = 1'b1;
        mode   = 2'd0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].flag, vecs[i].val, vecs[i].rdy);
            checkOutput("t1_valid", 64'(bus.rd_valid), 64'(vecs[i].exp_valid));
            checkOutput("t1_data",  64'(bus.rd_data),  64'(vecs[i].exp_data));
            checkOutput("t1_stamp", 64'(bus.rd_stamp), 64'(vecs[i].exp_stamp));
            checkOutput("t1_count", 64'(count),        64'(vecs[i].exp_count));
        end
        checkOutput("t1_empty",   64'(empty),   64'd1);
        checkOutput("t1_dropped", 64'(dropped), 64'd0);

        // STOP: the last four of twenty samples are lost
        do_reset();
        mode = 2'd0;
        for (int k = 1; k <= 20; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        checkOutput("t2_full",    64'(full),    64'd1);
        checkOutput("t2_count",   64'(count),   64'd16);
        checkOutput("t2_dropped", 64'(dropped), 64'd4);
        for (int k = 1; k <= 16; k++) begin
            checkOutput("t2_drain", 64'(bus.rd_data), 64'(k));
            applyStimulus(1'b0, 32'd0, 1'b1);
        end
        checkOutput("t2_empty", 64'(empty), 64'd1);

        // OVERWRITE: the first four are lost; stamps stay consecutive
        do_reset();
        mode = 2'd1;
        for (int k = 1; k <= 20; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        checkOutput("t3_dropped", 64'(dropped), 64'd4);
        checkOutput("t3_count",   64'(count),   64'd16);
        for (int k = 5; k <= 20; k++) begin
            checkOutput("t3_data",  64'(bus.rd_data),  64'(k));
            checkOutput("t3_stamp", 64'(bus.rd_stamp), 64'(k - 1));
            applyStimulus(1'b0, 32'd0, 1'b1);
        end

        // ONESHOT: freeze on full, ignore later strobes until clear
        do_reset();
        mode = 2'd2;
        for (int k = 1; k <= 16; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        checkOutput("t4_frozen", 64'(frozen), 64'd1);
        for (int k = 17; k <= 21; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        checkOutput("t4_dropped", 64'(dropped), 64'd0);
        checkOutput("t4_count",   64'(count),   64'd16);
        for (int k = 1; k <= 16; k++) begin
            checkOutput("t4_drain", 64'(bus.rd_data), 64'(k));
            applyStimulus(1'b0, 32'd0, 1'b1);
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h33, 1'b0);
        checkOutput("t4_still_frozen", 64'(frozen), 64'd1);
        checkOutput("t4_ignored",       64'(count),  64'd0);
        clear = 1'b1;
        applyStimulus(1'b1, 32'h77, 1'b0);
        clear = 1'b0;
        checkOutput("t4_clear_frozen", 64'(frozen), 64'd0);
        checkOutput("t4_clear_count",  64'(count),  64'd0);
        applyStimulus(1'b1, 32'hAA, 1'b0);
        checkOutput("t4_aa_data",  64'(bus.rd_data),  64'hAA);
        checkOutput("t4_aa_stamp", 64'(bus.rd_stamp), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("t4_aa_empty", 64'(empty), 64'd1);

        // Full FIFO with simultaneous write and read keeps every sample
        do_reset();
        mode = 2'd0;
        for (int k = 1; k <= 16; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'(100 + k), 1'b1);
        checkOutput("t5_count",   64'(count),       64'd16);
        checkOutput("t5_dropped", 64'(dropped),     64'd0);
        checkOutput("t5_head",    64'(bus.rd_data), 64'd4);
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("t5_empty", 64'(empty), 64'd1);

        // Async reset mid-drain, then saturation of the drop counter
        do_reset();
        mode = 2'd0;
        for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("t6_count_before", 64'(count), 64'd8);
        do_reset();
        applyStimulus(1'b1, 32'h55, 1'b0);
        checkOutput("t6_stamp_restart", 64'(bus.rd_stamp), 64'd0);
        checkOutput("t6_data",          64'(bus.rd_data),  64'h55);
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        for (int k = 0; k < 300; k++) applyStimulus(1'b1, 32'(k), 1'b0);
        checkOutput("t6_saturated", 64'(dropped), 64'd255);

        // Randomized traffic with mode changes, clears and one mid-run reset
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic f;
            logic r;
            if (cyc % 40 == 0) mode = 2'($urandom_range(0, 3));
            if (cyc == 300) do_reset();
            enable = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 79) == 0);
            f      = ($urandom_range(0, 3) != 0);
            if (((cyc / 100) % 2) == 0) r = ($urandom_range(0, 4) == 0);
            else                        r = ($urandom_range(0, 3) != 0);
            applyStimulus(f, $urandom, r);
        end
        clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
